// File: rtl/bp_pkg.sv
// Shared types for the branch-prediction resolve queue: queue entry layout,
// mispredict cause encoding and the sequential-fetch PC step.
package bp_pkg;

  localparam int BP_PC_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               taken;
    logic [BP_PC_W-1:0] target;
  } bp_entry_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    DIR  = 2'b01,
    TGT  = 2'b10
  } mis_cause_t;

endpackage

// File: rtl/bp_fifo.sv
// Circular in-order storage for in-flight predictions. Pointers carry one
// extra wrap bit so full and empty are distinguishable.
module bp_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  bp_entry_t     wr_entry,
  output bp_entry_t     head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  bp_entry_t   mem_q [DEPTH];

  // A flush always accompanies the popping resolution, so the queue ends
  // empty and any same-cycle push is treated as wrong-path.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (pop) rptr_d = rptr_q + (AW+1)'(1);
    if (flush) wptr_d = rptr_q + (AW+1)'(1);
    else if (push) wptr_d = wptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q[AW-1:0]] <= wr_entry;
  end

  assign head  = mem_q[rptr_q[AW-1:0]];
  assign count = wptr_q - rptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bp_resolve_queue.sv
// Checks queued branch predictions against resolved outcomes in program
// order, emitting predictor updates and a registered redirect on mispredict.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = BP_PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [1:0]               mis_cause,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   count
);

  bp_entry_t  wr_entry, head;
  logic       full, empty, push, pop, flush;
  logic [PC_W-1:0] head_pc, head_target;
  mis_cause_t cause;

  logic            upd_valid_q, upd_valid_d;
  logic [PC_W-1:0] upd_pc_q, upd_pc_d;
  logic            upd_taken_q, upd_taken_d;
  logic            mispredict_q, mispredict_d;
  mis_cause_t      mis_cause_q, mis_cause_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            res_err_q, res_err_d;

  assign wr_entry.pc     = BP_PC_W'(pred_pc);
  assign wr_entry.taken  = pred_taken;
  assign wr_entry.target = BP_PC_W'(pred_target);

  assign pred_ready  = !full;
  assign push        = pred_valid && !full;
  assign pop         = res_valid && !empty;
  assign head_pc     = PC_W'(head.pc);
  assign head_target = PC_W'(head.target);

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Direction errors take priority; a target is only judged when both agree on taken.
  always_comb begin
    cause = NONE;
    if (head.taken != res_taken) cause = DIR;
    else if (head.taken && (head_target != res_target)) cause = TGT;
  end

  assign flush = pop && (cause != NONE);

  always_comb begin
    upd_valid_d   = pop;
    upd_pc_d      = pop ? head_pc : '0;
    upd_taken_d   = pop ? res_taken : 1'b0;
    mispredict_d  = flush;
    mis_cause_d   = flush ? cause : NONE;
    redirect_pc_d = '0;
    if (flush) redirect_pc_d = res_taken ? res_target : head_pc + PC_W'(PC_STEP);
    res_err_d     = res_valid && empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      mis_cause_q   <= NONE;
      redirect_pc_q <= '0;
      res_err_q     <= 1'b0;
    end else begin
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
      mis_cause_q   <= mis_cause_d;
      redirect_pc_q <= redirect_pc_d;
      res_err_q     <= res_err_d;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign upd_taken   = upd_taken_q;
  assign mispredict  = mispredict_q;
  assign mis_cause   = mis_cause_q;
  assign redirect_pc = redirect_pc_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed self-checking bench for bp_resolve_queue: in-order resolution,
// DIR/TGT mispredicts with flush, full/empty corners, PC wrap and async reset.
module tb_bp_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        mispredict;
  logic [1:0]  mis_cause;
  logic [31:0] redirect_pc;
  logic        res_err;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  bp_resolve_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .mispredict  (mispredict),
    .mis_cause   (mis_cause),
    .redirect_pc (redirect_pc),
    .res_err     (res_err),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive push/resolve inputs, take the edge, sample 1 time unit later.
  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic pt,
                               input logic [31:0] ptgt, input logic rv, input logic rt,
                               input logic [31:0] rtgt);
    pred_valid  = pv;
    pred_pc     = pc;
    pred_taken  = pt;
    pred_target = ptgt;
    res_valid   = rv;
    res_taken   = rt;
    res_target  = rtgt;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    #12;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ready", 32'(pred_ready), 32'd1);
    checkOutput("rst_upd_valid", 32'(upd_valid), 32'd0);
    checkOutput("rst_mispredict", 32'(mispredict), 32'd0);
    checkOutput("rst_cause", 32'(mis_cause), 32'd0);
    checkOutput("rst_redirect", redirect_pc, 32'd0);
    checkOutput("rst_res_err", 32'(res_err), 32'd0);
    rst = 1'b0;

    // Correct taken prediction
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_count_push", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    checkOutput("t1_upd_valid", 32'(upd_valid), 32'd1);
    checkOutput("t1_upd_pc", upd_pc, 32'h100);
    checkOutput("t1_upd_taken", 32'(upd_taken), 32'd1);
    checkOutput("t1_mispredict", 32'(mispredict), 32'd0);
    checkOutput("t1_count", 32'(count), 32'd0);
    idle();
    checkOutput("t1_upd_pulse", 32'(upd_valid), 32'd0);

    // Direction mispredict
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
    checkOutput("t2_mispredict", 32'(mispredict), 32'd1);
    checkOutput("t2_cause", 32'(mis_cause), 32'd1);
    checkOutput("t2_redirect", redirect_pc, 32'h300);
    checkOutput("t2_upd_taken", 32'(upd_taken), 32'd1);
    idle();
    checkOutput("t2_mis_pulse", 32'(mispredict), 32'd0);

    // Target mispredict flushes younger entries
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t3_count3", 32'(count), 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h240);
    checkOutput("t3_mispredict", 32'(mispredict), 32'd1);
    checkOutput("t3_cause", 32'(mis_cause), 32'd2);
    checkOutput("t3_redirect", redirect_pc, 32'h240);
    checkOutput("t3_count", 32'(count), 32'd0);

    // Fill, then push while full alongside a correct pop
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h10 + 32'(4*i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_count_full", 32'(count), 32'd4);
    checkOutput("t4_ready_full", 32'(pred_ready), 32'd0);
    applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_count_after", 32'(count), 32'd3);
    checkOutput("t4_upd_pc", upd_pc, 32'h10);
    checkOutput("t4_mispredict", 32'(mispredict), 32'd0);
    checkOutput("t4_ready", 32'(pred_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_drain_pc", upd_pc, 32'h14 + 32'(4*i));
      checkOutput("t4_drain_valid", 32'(upd_valid), 32'd1);
    end
    checkOutput("t4_drained", 32'(count), 32'd0);

    // Mispredicting pop with a same-cycle push drops the push
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_mispredict", 32'(mispredict), 32'd1);
    checkOutput("t5_cause", 32'(mis_cause), 32'd1);
    checkOutput("t5_redirect", redirect_pc, 32'h44);
    checkOutput("t5_count", 32'(count), 32'd0);

    // Resolution while empty
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500);
    checkOutput("t5_res_err", 32'(res_err), 32'd1);
    checkOutput("t5_err_upd", 32'(upd_valid), 32'd0);
    checkOutput("t5_err_mis", 32'(mispredict), 32'd0);
    checkOutput("t5_err_count", 32'(count), 32'd0);
    idle();
    checkOutput("t5_err_pulse", 32'(res_err), 32'd0);

    // Fall-through PC wraps
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_mispredict", 32'(mispredict), 32'd1);
    checkOutput("t6_redirect_wrap", redirect_pc, 32'h0);

    // Asynchronous reset with entries held and an update pulse showing
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h200 + 32'(4*i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("t7_count3", 32'(count), 32'd3);
    checkOutput("t7_upd_before", 32'(upd_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t7_count", 32'(count), 32'd0);
    checkOutput("t7_upd_valid", 32'(upd_valid), 32'd0);
    checkOutput("t7_upd_pc", upd_pc, 32'h0);
    checkOutput("t7_ready", 32'(pred_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
